dac_reg_spi_arbiter: RTL
========================

Name: dac_reg_spi_arbiter

Overview:
- Shares the single DAC/register SPI master between two requesters.
  - The sine-generator sample path writes DAC codes.
  - The measurement FSM writes the keys/range register.
- Owns the chip-select pair, the SPI start strobe, CS setup/hold timing and transfer timeout.
- Sits between the requesters and the spi_master that drives dac_reg_sck/mosi.

Parameters:
- DATA_WIDTH, 8, SPI word width.
- CS_SETUP, 2, clk cycles CS is asserted before spi_start (min 1).
- CS_HOLD, 2, clk cycles CS stays asserted after spi_new_data (min 1).
- TIMEOUT, 255, max clk cycles in XFER waiting for spi_new_data before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- dac_stb  in  1  one-cycle request: write dac_data to DAC.
- dac_data  in  DATA_WIDTH  DAC code, sampled when dac_stb=1.
- dac_ack  out  1  one-cycle pulse: DAC word transferred.
- reg_stb  in  1  one-cycle request: write reg_data to register.
- reg_data  in  DATA_WIDTH  {diap,keys} word, sampled when reg_stb=1 and reg_busy=0.
- reg_busy  out  1  reg request pending or in flight.
- reg_ack  out  1  one-cycle pulse: register word transferred.
- spi_start  out  1  start strobe to spi_master.
- spi_data_in  out  DATA_WIDTH  word to spi_master.
- spi_busy  in  1  spi_master busy.
- spi_new_data  in  1  spi_master transfer-complete pulse.
- cs_dac_reg  out  2  active-low selects: 2'b11 none, 2'b01 DAC, 2'b10 REG.
- timeout_err  out  1  one-cycle pulse on transfer abort.

Behaviour:
- Reset (async, rst=1): all outputs 0 except cs_dac_reg=2'b11; pending flags, shadow regs and counters cleared; state IDLE. rst mid-transfer deasserts CS immediately. The spi_master shares rst.
- Capture:
  - dac_stb sets dac_pend and loads dac_shadow at the same edge.
  - dac_stb while dac_pend=1 overwrites dac_shadow; the latest sample wins.
  - reg_stb with reg_busy=0 sets reg_pend and loads reg_shadow.
  - reg_stb with reg_busy=1 is ignored.
  - reg_busy = reg_pend OR (state≠IDLE AND sel=REG).
- FSM states: IDLE, SETUP, START, XFER, HOLD. All outputs are registered.
- IDLE:
  - cs=11.
  - If dac_pend: sel=DAC, clear dac_pend, latch word to spi_data_in, go SETUP.
  - Else if reg_pend: same with sel=REG.
  - Fixed priority: DAC beats REG when both are pending.
- SETUP:
  - cs per sel.
  - Stay CS_SETUP cycles, then go START.
  - spi_data_in is stable from SETUP entry through XFER.
- START:
  - spi_start=1 for exactly one cycle.
  - Go XFER.
  - If spi_busy=1 on entry, hold START with spi_start=0 until spi_busy=0, then pulse.
- XFER:
  - Wait for spi_new_data, counting cycles.
  - On spi_new_data: go HOLD and pulse the ack matching sel in the next cycle.
  - If the count reaches TIMEOUT: pulse timeout_err, no ack, go HOLD.
- HOLD:
  - cs stays asserted CS_HOLD cycles, then go IDLE.
  - IDLE always drives cs=11 for ≥1 cycle between transfers.
- Latency from strobe at cycle N with the arbiter idle:
  - pend visible N+1.
  - SETUP/CS asserted N+2.
  - spi_start N+2+CS_SETUP.
- Simultaneous events:
  - dac_stb in the same cycle IDLE grants DAC from dac_pend: the new word becomes pending for the next transfer.
  - dac_stb and reg_stb together: both captured; DAC served first, REG next.
- Counters:
  - Setup/hold counter is width $clog2(max(CS_SETUP,CS_HOLD)+1).
  - Timeout counter is width $clog2(TIMEOUT+1); it does not wrap.
- cs_dac_reg never takes the value 2'b00.

Optional Feature:
- Macro: DAC_REG_ARB_OVERRUN_CNT_EN.
- Defined:
  - Adds output dac_overrun_cnt [7:0].
  - Increments on each dac_stb arriving while dac_pend=1.
  - Saturates at 8'hFF; cleared only by rst.
- Undefined: the port and counter are absent; overwrite behaviour is unchanged.

Test Plan:
- DAC only, defaults: dac_stb at cycle 10 with dac_data=8'hA5 -> cs=01 from cycle 12, spi_start=1 at cycle 14 with spi_data_in=8'hA5. Model spi_new_data at cycle 30 -> dac_ack at cycle 31, cs=11 at cycle 33.
- Simultaneous dac_stb(8'h11) and reg_stb(8'h2C) -> DAC transfer (cs=01) completes first. At least one cycle with cs=11 follows. Then the REG transfer runs (cs=10) with spi_data_in=8'h2C; reg_busy stays high until the REG transfer returns to IDLE.
- Three dac_stb (8'h01,8'h02,8'h03) while the DAC is in flight -> exactly one further DAC transfer, carrying 8'h03. With DAC_REG_ARB_OVERRUN_CNT_EN defined, dac_overrun_cnt=2.
- reg_stb(8'h55) then reg_stb(8'hAA) while reg_busy=1 -> single REG transfer of 8'h55, one reg_ack.
- TIMEOUT=16, spi_new_data never asserted -> timeout_err pulse 16 cycles after XFER entry, no ack, cs=11 after CS_HOLD, next pending request serviced normally.
- rst asserted mid-XFER -> same cycle (async) cs=11, spi_start=0, acks 0. After release, no stale transfer is issued.

Source files
------------

// File: rtl/dac_reg_spi_arbiter.sv
// Shares one DAC/register SPI master between the DAC sample path and the register writer.
// Optional DAC overrun counter output enabled by defining DAC_REG_ARB_OVERRUN_CNT_EN.
module dac_reg_spi_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dac_stb_i,
    input  logic [DATA_WIDTH-1:0] dac_data_i,
    output logic                  dac_ack_o,
    input  logic                  reg_stb_i,
    input  logic [DATA_WIDTH-1:0] reg_data_i,
    output logic                  reg_busy_o,
    output logic                  reg_ack_o,
    output logic                  spi_start_o,
    output logic [DATA_WIDTH-1:0] spi_data_in_o,
    input  logic                  spi_busy_i,
    input  logic                  spi_new_data_i,
    output logic [1:0]            cs_dac_reg_o,
    output logic                  timeout_err_o
`ifdef DAC_REG_ARB_OVERRUN_CNT_EN
    ,
    output logic [7:0]            dac_overrun_cnt_o
`endif
);

    localparam int unsigned ShMax = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned ShW   = $clog2(ShMax + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT + 1);

    localparam logic [ShW-1:0] SetupLast = ShW'(CS_SETUP - 1);
    localparam logic [ShW-1:0] HoldLast  = ShW'(CS_HOLD - 1);
    localparam logic [ToW-1:0] ToLast    = ToW'(TIMEOUT - 1);

    localparam logic SelDac = 1'b0;
    localparam logic SelReg = 1'b1;

    typedef enum logic [2:0] {StIdle, StSetup, StStart, StXfer, StHold} state_e;

    state_e                state_q, state_d;
    logic                  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] dac_shadow_q, dac_shadow_d;
    logic [DATA_WIDTH-1:0] reg_shadow_q, reg_shadow_d;
    logic                  dac_pend_q, dac_pend_d;
    logic                  reg_pend_q, reg_pend_d;
    logic [ShW-1:0]        sh_cnt_q, sh_cnt_d;
    logic [ToW-1:0]        to_cnt_q, to_cnt_d;
    logic                  start_q, start_d;
    logic                  dac_ack_q, dac_ack_d;
    logic                  reg_ack_q, reg_ack_d;
    logic                  to_err_q, to_err_d;
    logic [1:0]            cs_q, cs_d;
    logic                  reg_busy_q, reg_busy_d;
    logic [7:0]            dac_ovr_q, dac_ovr_d;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        data_d       = data_q;
        dac_shadow_d = dac_shadow_q;
        reg_shadow_d = reg_shadow_q;
        dac_pend_d   = dac_pend_q;
        reg_pend_d   = reg_pend_q;
        sh_cnt_d     = sh_cnt_q;
        to_cnt_d     = to_cnt_q;
        start_d      = 1'b0;
        dac_ack_d    = 1'b0;
        reg_ack_d    = 1'b0;
        to_err_d     = 1'b0;
        dac_ovr_d    = dac_ovr_q;

        if (dac_stb_i) begin
            dac_pend_d   = 1'b1;
            dac_shadow_d = dac_data_i;
            if (dac_pend_q && dac_ovr_q != 8'hFF) begin
                dac_ovr_d = dac_ovr_q + 8'd1;
            end
        end
        if (reg_stb_i && !reg_busy_q) begin
            reg_pend_d   = 1'b1;
            reg_shadow_d = reg_data_i;
        end

        case (state_q)
            StIdle: begin
                if (dac_pend_q) begin
                    sel_d    = SelDac;
                    // A strobe arriving with the grant keeps the new word pending
                    if (!dac_stb_i) dac_pend_d = 1'b0;
                    data_d   = dac_shadow_q;
                    sh_cnt_d = '0;
                    state_d  = StSetup;
                end else if (reg_pend_q) begin
                    sel_d      = SelReg;
                    reg_pend_d = 1'b0;
                    data_d     = reg_shadow_q;
                    sh_cnt_d   = '0;
                    state_d    = StSetup;
                end
            end
            StSetup: begin
                if (sh_cnt_q == SetupLast) begin
                    state_d = StStart;
                    start_d = !spi_busy_i;
                end else begin
                    sh_cnt_d = sh_cnt_q + ShW'(1);
                end
            end
            StStart: begin
                if (start_q) begin
                    state_d  = StXfer;
                    to_cnt_d = '0;
                end else if (!spi_busy_i) begin
                    start_d = 1'b1;
                end
            end
            StXfer: begin
                if (spi_new_data_i) begin
                    state_d   = StHold;
                    sh_cnt_d  = '0;
                    dac_ack_d = (sel_q == SelDac);
                    reg_ack_d = (sel_q == SelReg);
                end else if (to_cnt_q == ToLast) begin
                    state_d  = StHold;
                    sh_cnt_d = '0;
                    to_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end
            StHold: begin
                if (sh_cnt_q == HoldLast) begin
                    state_d = StIdle;
                end else begin
                    sh_cnt_d = sh_cnt_q + ShW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Decode from next state so the registered outputs line up with the state
        if (state_d == StIdle) begin
            cs_d = 2'b11;
        end else begin
            cs_d = (sel_d == SelReg) ? 2'b10 : 2'b01;
        end
        reg_busy_d = reg_pend_d || ((state_d != StIdle) && (sel_d == SelReg));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= SelDac;
            data_q       <= '0;
            dac_shadow_q <= '0;
            reg_shadow_q <= '0;
            dac_pend_q   <= 1'b0;
            reg_pend_q   <= 1'b0;
            sh_cnt_q     <= '0;
            to_cnt_q     <= '0;
            start_q      <= 1'b0;
            dac_ack_q    <= 1'b0;
            reg_ack_q    <= 1'b0;
            to_err_q     <= 1'b0;
            cs_q         <= 2'b11;
            reg_busy_q   <= 1'b0;
            dac_ovr_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            data_q       <= data_d;
            dac_shadow_q <= dac_shadow_d;
            reg_shadow_q <= reg_shadow_d;
            dac_pend_q   <= dac_pend_d;
            reg_pend_q   <= reg_pend_d;
            sh_cnt_q     <= sh_cnt_d;
            to_cnt_q     <= to_cnt_d;
            start_q      <= start_d;
            dac_ack_q    <= dac_ack_d;
            reg_ack_q    <= reg_ack_d;
            to_err_q     <= to_err_d;
            cs_q         <= cs_d;
            reg_busy_q   <= reg_busy_d;
            dac_ovr_q    <= dac_ovr_d;
        end
    end

    assign dac_ack_o     = dac_ack_q;
    assign reg_ack_o     = reg_ack_q;
    assign reg_busy_o    = reg_busy_q;
    assign spi_start_o   = start_q;
    assign spi_data_in_o = data_q;
    assign cs_dac_reg_o  = cs_q;
    assign timeout_err_o = to_err_q;

`ifdef DAC_REG_ARB_OVERRUN_CNT_EN
    assign dac_overrun_cnt_o = dac_ovr_q;
`else
    logic unused_ovr;
    assign unused_ovr = ^dac_ovr_q;
`endif

endmodule
